// File: rtl/dpb_bank_scheduler.sv
// Queues "bank filled" descriptors from the MJPEG DPB writer and hands them one at a
// time to the DDR3 master write engine, tracking free banks, overflow and consumer timeout.
module dpb_bank_scheduler #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned AFULL_LVL   = 13,
   parameter logic [31:0] TIMEOUT_CYC = 32'd2700000
) (
   input  logic        i_pclk,
   input  logic        i_rst_n,
   input  logic        i_wr_req,
   input  logic [3:0]  i_wr_buf_rank,
   input  logic [6:0]  i_wr_buf_128cnt,
   input  logic [5:0]  i_wr_buf_bytecnt,
   input  logic [7:0]  i_wr_udp_rank,
   input  logic        i_wr_eof,
   output logic        o_cmd_valid,
   output logic [3:0]  o_cmd_buf_rank,
   output logic [6:0]  o_cmd_128cnt,
   output logic [5:0]  o_cmd_bytecnt,
   output logic [7:0]  o_cmd_udp_rank,
   output logic        o_cmd_eof,
   input  logic        i_cmd_done,
   output logic [4:0]  o_free_banks,
   output logic        o_almost_full,
   output logic        o_overflow,
   output logic        o_timeout,
   output logic [15:0] o_frame_cnt
);

   localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]       DEPTH_C   = 5'(DEPTH);
   localparam logic [4:0]       AFULL_C   = 5'(AFULL_LVL);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [31:0]      WDOG_LAST = TIMEOUT_CYC - 32'd1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [25:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [4:0]       count;
   logic [4:0]       occ;
   logic [25:0]      head;
   logic [25:0]      wr_entry;
   logic [31:0]      wdog;
   logic             exit_done;
   logic             inflight;
   logic             push;
   logic             drop;
   logic             pop;
   logic             done_acc;
   logic             wdog_exp;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // A bank held by the in-flight descriptor cannot be refilled, so it counts toward full.
   assign inflight = (state != IDLE);
   assign occ      = count + {4'd0, inflight};
   assign push     = i_wr_req && (occ < DEPTH_C);
   assign drop     = i_wr_req && !push;
   assign pop      = (state == IDLE) && (count != 5'd0);
   assign done_acc = (state == WAIT_DONE) && o_cmd_valid && i_cmd_done;
   assign wdog_exp = (state == WAIT_DONE) && !done_acc && (wdog >= WDOG_LAST);
   assign wr_entry = {i_wr_eof, i_wr_udp_rank, i_wr_buf_bytecnt, i_wr_buf_128cnt, i_wr_buf_rank};
   assign head     = mem[rd_ptr];

   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (pop) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_DONE;
         WAIT_DONE: if (done_acc || wdog_exp) state_nxt = RELEASE;
         RELEASE:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Descriptor storage is pure data; pointers and count carry the queue state.
   always_ff @(posedge i_pclk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 5'd0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

   // Command outputs, watchdog and status flags.
   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_cmd_valid    <= 1'b0;
         o_cmd_eof      <= 1'b0;
         o_cmd_udp_rank <= 8'd0;
         o_cmd_bytecnt  <= 6'd0;
         o_cmd_128cnt   <= 7'd0;
         o_cmd_buf_rank <= 4'd0;
         wdog           <= 32'd0;
         exit_done      <= 1'b0;
         o_overflow     <= 1'b0;
         o_timeout      <= 1'b0;
         o_frame_cnt    <= 16'd0;
         o_free_banks   <= DEPTH_C;
         o_almost_full  <= 1'b0;
      end else begin
         if (pop) begin
            {o_cmd_eof, o_cmd_udp_rank, o_cmd_bytecnt, o_cmd_128cnt, o_cmd_buf_rank} <= head;
         end
         if (state == ISSUE) begin
            o_cmd_valid <= 1'b1;
            wdog        <= 32'd0;
         end
         if (state == WAIT_DONE) begin
            wdog <= sat_inc32(wdog);
            if (done_acc || wdog_exp) begin
               o_cmd_valid <= 1'b0;
               exit_done   <= done_acc;
            end
         end
         if (wdog_exp) o_timeout <= 1'b1;
         if ((state == RELEASE) && o_cmd_eof && exit_done) o_frame_cnt <= o_frame_cnt + 16'd1;
         if (drop) o_overflow <= 1'b1;
         o_free_banks  <= DEPTH_C - occ;
         o_almost_full <= (occ >= AFULL_C);
      end
   end

endmodule

// File: tb/tb_dpb_bank_scheduler.sv
// Bench for dpb_bank_scheduler: directed scenarios plus a randomized run scored
// against a descriptor-queue reference model.
module tb_dpb_bank_scheduler;

   typedef struct packed {
      logic       eof;
      logic [7:0] udp;
      logic [5:0] bc;
      logic [6:0] c128;
      logic [3:0] rank;
   } desc_t;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_wr_req = 1'b0;
   logic [3:0]  i_wr_buf_rank = '0;
   logic [6:0]  i_wr_buf_128cnt = '0;
   logic [5:0]  i_wr_buf_bytecnt = '0;
   logic [7:0]  i_wr_udp_rank = '0;
   logic        i_wr_eof = 1'b0;
   logic        i_cmd_done = 1'b0;
   logic        o_cmd_valid;
   logic [3:0]  o_cmd_buf_rank;
   logic [6:0]  o_cmd_128cnt;
   logic [5:0]  o_cmd_bytecnt;
   logic [7:0]  o_cmd_udp_rank;
   logic        o_cmd_eof;
   logic [4:0]  o_free_banks;
   logic        o_almost_full;
   logic        o_overflow;
   logic        o_timeout;
   logic [15:0] o_frame_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dpb_bank_scheduler #(.DEPTH(16), .AFULL_LVL(13), .TIMEOUT_CYC(32'd100)) dut (
      .i_pclk(clk), .i_rst_n(i_rst_n),
      .i_wr_req(i_wr_req), .i_wr_buf_rank(i_wr_buf_rank), .i_wr_buf_128cnt(i_wr_buf_128cnt),
      .i_wr_buf_bytecnt(i_wr_buf_bytecnt), .i_wr_udp_rank(i_wr_udp_rank), .i_wr_eof(i_wr_eof),
      .o_cmd_valid(o_cmd_valid), .o_cmd_buf_rank(o_cmd_buf_rank), .o_cmd_128cnt(o_cmd_128cnt),
      .o_cmd_bytecnt(o_cmd_bytecnt), .o_cmd_udp_rank(o_cmd_udp_rank), .o_cmd_eof(o_cmd_eof),
      .i_cmd_done(i_cmd_done), .o_free_banks(o_free_banks), .o_almost_full(o_almost_full),
      .o_overflow(o_overflow), .o_timeout(o_timeout), .o_frame_cnt(o_frame_cnt)
   );

   function automatic desc_t obs();
      return {o_cmd_eof, o_cmd_udp_rank, o_cmd_bytecnt, o_cmd_128cnt, o_cmd_buf_rank};
   endfunction

   function automatic desc_t rand_desc();
      logic [31:0] r;
      r = $urandom;
      return r[25:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input desc_t d);
      {i_wr_eof, i_wr_udp_rank, i_wr_buf_bytecnt, i_wr_buf_128cnt, i_wr_buf_rank} = d;
      i_wr_req = 1'b1;
      tick();
      i_wr_req = 1'b0;
   endtask

   task automatic pulse_done();
      i_cmd_done = 1'b1;
      tick();
      i_cmd_done = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (o_cmd_valid) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic apply_reset();
      i_rst_n = 1'b0;
      repeat (2) tick();
      i_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_tests++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_cmd_valid); end
      n_tests++; if (obs() !== 26'd0) begin n_fail++; $display("FAIL rst_fields: got %h want 0", obs()); end
      n_tests++; if (o_free_banks !== 5'd16) begin n_fail++; $display("FAIL rst_free: got %0d want 16", o_free_banks); end
      n_tests++; if ({o_almost_full, o_overflow, o_timeout} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {o_almost_full, o_overflow, o_timeout}); end
      n_tests++; if (o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame: got %0d want 0", o_frame_cnt); end
      i_rst_n = 1'b1;
      repeat (3) tick();
      n_tests++; if (o_cmd_valid !== 1'b0 || o_free_banks !== 5'd16) begin n_fail++; $display("FAIL rst_idle: valid %b free %0d want 0/16", o_cmd_valid, o_free_banks); end
   endtask

   task automatic test_single();
      desc_t d;
      d = '{eof: 1'b0, udp: 8'd1, bc: 6'd0, c128: 7'd91, rank: 4'd3};
      push(d);
      tick();
      n_tests++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: valid %b at N+2 want 0", o_cmd_valid); end
      tick();
      n_tests++; if (o_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: valid %b at N+3 want 1", o_cmd_valid); end
      n_tests++; if (obs() !== d) begin n_fail++; $display("FAIL single_fields: got %h want %h", obs(), d); end
      n_tests++; if (o_free_banks !== 5'd15) begin n_fail++; $display("FAIL single_free_busy: got %0d want 15", o_free_banks); end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++; if (o_cmd_valid !== 1'b1 || obs() !== d) begin n_fail++; $display("FAIL single_stable: valid %b fields %h want 1/%h", o_cmd_valid, obs(), d); end
      end
      pulse_done();
      n_tests++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: valid %b want 0", o_cmd_valid); end
      repeat (2) tick();
      n_tests++; if (o_free_banks !== 5'd16) begin n_fail++; $display("FAIL single_free_back: got %0d want 16", o_free_banks); end
      n_tests++; if (o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL single_frame: got %0d want 0", o_frame_cnt); end
   endtask

   task automatic test_push_pop();
      desc_t a, b;
      bit ok;
      int extra;
      a = rand_desc(); a.eof = 1'b0;
      b = rand_desc(); b.eof = 1'b0;
      push(a);
      push(b);
      tick();
      n_tests++; if (o_free_banks !== 5'd14) begin n_fail++; $display("FAIL pp_free: got %0d want 14", o_free_banks); end
      wait_valid(10, ok);
      n_tests++; if (!ok || obs() !== a) begin n_fail++; $display("FAIL pp_first: got %h want %h (valid seen %b)", obs(), a, ok); end
      pulse_done();
      wait_valid(10, ok);
      n_tests++; if (!ok || obs() !== b) begin n_fail++; $display("FAIL pp_second: got %h want %h (valid seen %b)", obs(), b, ok); end
      pulse_done();
      extra = 0;
      repeat (20) begin if (o_cmd_valid) extra++; tick(); end
      n_tests++; if (extra != 0 || o_free_banks !== 5'd16) begin n_fail++; $display("FAIL pp_dup: extra valid cycles %0d free %0d want 0/16", extra, o_free_banks); end
   endtask

   task automatic test_ordering();
      desc_t d [5];
      bit ok;
      logic [4:0] minf;
      logic [15:0] f0;
      f0 = o_frame_cnt;
      minf = 5'd31;
      for (int k = 0; k < 5; k++) begin
         d[k] = rand_desc();
         d[k].rank = 4'(k);
         d[k].eof = (k == 4);
         if (k == 4) d[k].bc = 6'd7;
      end
      for (int k = 0; k < 5; k++) push(d[k]);
      repeat (10) begin if (o_free_banks < minf) minf = o_free_banks; tick(); end
      for (int k = 0; k < 5; k++) begin
         wait_valid(20, ok);
         n_tests++; if (!ok || obs() !== d[k]) begin n_fail++; $display("FAIL order_%0d: got %h want %h (valid seen %b)", k, obs(), d[k], ok); end
         if (o_free_banks < minf) minf = o_free_banks;
         pulse_done();
      end
      repeat (4) tick();
      n_tests++; if (minf !== 5'd11) begin n_fail++; $display("FAIL order_min_free: got %0d want 11", minf); end
      n_tests++; if (o_frame_cnt !== f0 + 16'd1) begin n_fail++; $display("FAIL order_frame: got %0d want %0d", o_frame_cnt, f0 + 16'd1); end
   endtask

   task automatic test_overflow();
      desc_t q [$];
      desc_t d;
      bit ok;
      int issued, extra;
      apply_reset();
      for (int i = 0; i < 17; i++) begin
         d = rand_desc();
         d.rank = 4'(i);
         d.udp = 8'(i);
         if (i < 16) q.push_back(d);
         push(d);
      end
      repeat (2) tick();
      n_tests++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
      n_tests++; if (o_almost_full !== 1'b1) begin n_fail++; $display("FAIL ovf_afull: got %b want 1", o_almost_full); end
      n_tests++; if (o_free_banks !== 5'd0) begin n_fail++; $display("FAIL ovf_free: got %0d want 0", o_free_banks); end
      issued = 0;
      for (int i = 0; i < 16; i++) begin
         wait_valid(30, ok);
         n_tests++; if (!ok || obs() !== q[i]) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h want %h (valid seen %b)", i, obs(), q[i], ok); end
         if (ok) begin issued++; pulse_done(); end
      end
      extra = 0;
      repeat (30) begin if (o_cmd_valid) extra++; tick(); end
      n_tests++; if (issued != 16 || extra != 0) begin n_fail++; $display("FAIL ovf_count: issued %0d extra %0d want 16/0", issued, extra); end
      n_tests++; if (o_overflow !== 1'b1 || o_almost_full !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky: ovf %b afull %b want 1/0", o_overflow, o_almost_full); end
   endtask

   task automatic test_random();
      desc_t exp_q [$];
      desc_t cur, d;
      int outstanding, wait_c, target, low_c, issues, frames_m;
      bit prev_v;
      apply_reset();
      outstanding = 0; wait_c = 0; target = 0; low_c = 3; issues = 0; frames_m = 0;
      prev_v = 1'b0; cur = '0;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         i_wr_req = 1'b0;
         i_cmd_done = 1'b0;
         if (o_cmd_valid) begin
            if (!prev_v) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++; $display("FAIL rnd_spurious: issue %h with empty model queue", obs());
               end else begin
                  cur = exp_q.pop_front();
                  if (obs() !== cur) begin n_fail++; $display("FAIL rnd_issue_%0d: got %h want %h", issues, obs(), cur); end
               end
               n_tests++; if (issues > 0 && low_c < 3) begin n_fail++; $display("FAIL rnd_gap: got %0d idle cycles want >=3", low_c); end
               issues++;
               wait_c = 0;
               target = $urandom_range(0, 12);
            end else begin
               n_tests++; if (obs() !== cur) begin n_fail++; $display("FAIL rnd_stable: got %h want %h", obs(), cur); end
            end
            low_c = 0;
            if (wait_c >= target) begin
               i_cmd_done = 1'b1;
               outstanding--;
               if (cur.eof) frames_m++;
            end
            wait_c++;
         end else begin
            low_c++;
            if ($urandom_range(0, 7) == 0) i_cmd_done = 1'b1;
         end
         if (cyc < 2000 && outstanding < 12 && $urandom_range(0, 2) == 0) begin
            d = rand_desc();
            {i_wr_eof, i_wr_udp_rank, i_wr_buf_bytecnt, i_wr_buf_128cnt, i_wr_buf_rank} = d;
            i_wr_req = 1'b1;
            exp_q.push_back(d);
            outstanding++;
         end
         prev_v = o_cmd_valid;
         tick();
      end
      i_wr_req = 1'b0;
      i_cmd_done = 1'b0;
      repeat (4) tick();
      n_tests++; if (exp_q.size() != 0 || o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: %0d left valid %b want 0/0", exp_q.size(), o_cmd_valid); end
      n_tests++; if (o_frame_cnt !== 16'(frames_m)) begin n_fail++; $display("FAIL rnd_frame: got %0d want %0d", o_frame_cnt, frames_m); end
      n_tests++; if (o_free_banks !== 5'd16) begin n_fail++; $display("FAIL rnd_free: got %0d want 16", o_free_banks); end
      n_tests++; if (o_overflow !== 1'b0 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL rnd_flags: ovf %b to %b want 0/0", o_overflow, o_timeout); end
   endtask

   task automatic test_timeout();
      desc_t a, b;
      bit ok;
      int hi;
      logic [15:0] f0;
      f0 = o_frame_cnt;
      a = rand_desc(); a.eof = 1'b1;
      b = rand_desc(); b.eof = 1'b0;
      n_tests++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pre: got %b want 0", o_timeout); end
      push(a);
      push(b);
      wait_valid(20, ok);
      n_tests++; if (!ok || obs() !== a) begin n_fail++; $display("FAIL to_first: got %h want %h (valid seen %b)", obs(), a, ok); end
      hi = 0;
      while (o_cmd_valid && hi < 300) begin hi++; tick(); end
      n_tests++; if (hi != 100) begin n_fail++; $display("FAIL to_window: valid held %0d cycles want 100", hi); end
      n_tests++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", o_timeout); end
      wait_valid(20, ok);
      n_tests++; if (!ok || obs() !== b) begin n_fail++; $display("FAIL to_next: got %h want %h (valid seen %b)", obs(), b, ok); end
      pulse_done();
      repeat (4) tick();
      n_tests++; if (o_frame_cnt !== f0) begin n_fail++; $display("FAIL to_frame: got %0d want %0d", o_frame_cnt, f0); end
      n_tests++; if (o_timeout !== 1'b1 || o_free_banks !== 5'd16) begin n_fail++; $display("FAIL to_sticky: to %b free %0d want 1/16", o_timeout, o_free_banks); end
   endtask

   task automatic test_reset_mid();
      desc_t d;
      bit ok;
      int extra;
      for (int k = 0; k < 5; k++) begin
         d = rand_desc();
         d.rank = 4'(10 + k);
         d.eof = (k == 0);
         push(d);
      end
      wait_valid(20, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rm_issue: valid %b want 1", o_cmd_valid); end
      repeat (2) tick();
      #2;
      i_rst_n = 1'b0;
      #1;
      n_tests++; if (o_cmd_valid !== 1'b0 || obs() !== 26'd0) begin n_fail++; $display("FAIL rm_cmd: valid %b fields %h want 0/0", o_cmd_valid, obs()); end
      n_tests++; if (o_free_banks !== 5'd16 || o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_counts: free %0d frame %0d want 16/0", o_free_banks, o_frame_cnt); end
      n_tests++; if ({o_almost_full, o_overflow, o_timeout} !== 3'b000) begin n_fail++; $display("FAIL rm_flags: got %b want 000", {o_almost_full, o_overflow, o_timeout}); end
      @(posedge clk);
      #1;
      i_rst_n = 1'b1;
      tick();
      pulse_done();
      extra = 0;
      repeat (20) begin if (o_cmd_valid) extra++; tick(); end
      n_tests++; if (extra != 0) begin n_fail++; $display("FAIL rm_stale: %0d valid cycles after reset want 0", extra); end
      n_tests++; if (o_free_banks !== 5'd16 || o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_stray: free %0d frame %0d want 16/0", o_free_banks, o_frame_cnt); end
      d = rand_desc();
      push(d);
      repeat (2) tick();
      n_tests++; if (o_cmd_valid !== 1'b1 || obs() !== d) begin n_fail++; $display("FAIL rm_resume: valid %b fields %h want 1/%h", o_cmd_valid, obs(), d); end
      pulse_done();
      repeat (3) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_push_pop();
      test_ordering();
      test_overflow();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
